// File: rtl/axis_video_frame_checker_if.sv
// rtl/axis_video_frame_checker_if.sv - AXI4-Stream video beat interface (tdata/tvalid/tlast/tuser/tready)
interface axis_video_frame_checker_if #(
  parameter int N = 8
);
  logic [N-1:0] tdata;
  logic         tvalid;
  logic         tlast;
  logic         tuser;
  logic         tready;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_video_frame_checker.sv
// rtl/axis_video_frame_checker.sv - AXI4-Stream video sink that tracks position, checks framing and sums pixels
module axis_video_frame_checker #(
  parameter int N      = 8,
  parameter int width  = 10,
  parameter int height = 10
) (
  input  logic                          sys_clk,
  input  logic                          sys_aresetn,
  axis_video_frame_checker_if.slave     s_axis,
  input  logic                          hold,
  input  logic                          clr_errors,
  output logic [10:0]                   pixel_x,
  output logic [10:0]                   line_y,
  output logic                          in_frame,
  output logic                          frame_done,
  output logic [15:0]                   frame_count,
  output logic [31:0]                   frame_sum,
  output logic                          err_early_tlast,
  output logic                          err_late_tlast,
  output logic                          err_missing_tuser,
  output logic                          err_unexpected_tuser,
  output logic [15:0]                   drop_count
);

  typedef enum logic {WAIT_SOF, IN_FRAME} state_t;

  localparam logic [10:0] LAST_X = 11'(width - 1);
  localparam logic [10:0] LAST_Y = 11'(height - 1);

  state_t      state;
  logic [31:0] acc;

  logic        beat;
  logic        at_last_x;
  logic        at_last_y;
  logic [31:0] tdata_ext;
  logic [31:0] acc_next;
  logic [15:0] drop_base;
  logic [15:0] drop_next;

  always_comb begin
    beat      = s_axis.tvalid && s_axis.tready;
    at_last_x = (pixel_x == LAST_X);
    at_last_y = (line_y == LAST_Y);
    tdata_ext = 32'(s_axis.tdata);
    acc_next  = acc + tdata_ext;
    // A clear and a drop in the same cycle leave the count at one.
    drop_base = clr_errors ? 16'd0 : drop_count;
    drop_next = (drop_base == 16'hFFFF) ? drop_base : drop_base + 16'd1;
  end

  always_ff @(posedge sys_clk or negedge sys_aresetn) begin
    if (!sys_aresetn) begin
      state                <= WAIT_SOF;
      acc                  <= '0;
      s_axis.tready        <= 1'b0;
      pixel_x              <= '0;
      line_y               <= '0;
      in_frame             <= 1'b0;
      frame_done           <= 1'b0;
      frame_count          <= '0;
      frame_sum            <= '0;
      err_early_tlast      <= 1'b0;
      err_late_tlast       <= 1'b0;
      err_missing_tuser    <= 1'b0;
      err_unexpected_tuser <= 1'b0;
      drop_count           <= '0;
    end else begin
      s_axis.tready <= ~hold;
      frame_done    <= 1'b0;

      // Clear first so that any set later in this cycle wins.
      if (clr_errors) begin
        err_early_tlast      <= 1'b0;
        err_late_tlast       <= 1'b0;
        err_missing_tuser    <= 1'b0;
        err_unexpected_tuser <= 1'b0;
        drop_count           <= '0;
      end

      if (beat) begin
        case (state)
          WAIT_SOF: begin
            if (!s_axis.tuser) begin
              drop_count        <= drop_next;
              err_missing_tuser <= 1'b1;
            end else begin
              acc      <= tdata_ext;
              pixel_x  <= 11'd1;
              line_y   <= '0;
              state    <= IN_FRAME;
              in_frame <= 1'b1;
            end
          end

          IN_FRAME: begin
            if (s_axis.tuser) begin
              // Abandon the partial frame and restart from this beat.
              err_unexpected_tuser <= 1'b1;
              acc                  <= tdata_ext;
              pixel_x              <= 11'd1;
              line_y               <= '0;
            end else begin
              acc <= acc_next;
              if (at_last_x && !s_axis.tlast) err_late_tlast  <= 1'b1;
              if (!at_last_x && s_axis.tlast) err_early_tlast <= 1'b1;

              if (at_last_x || s_axis.tlast) begin
                pixel_x <= '0;
                if (at_last_y) begin
                  frame_done  <= 1'b1;
                  frame_count <= frame_count + 16'd1;
                  frame_sum   <= acc_next;
                  line_y      <= '0;
                  state       <= WAIT_SOF;
                  in_frame    <= 1'b0;
                end else begin
                  line_y <= line_y + 11'd1;
                end
              end else begin
                pixel_x <= pixel_x + 11'd1;
              end
            end
          end

          default: state <= WAIT_SOF;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axis_video_frame_checker.sv
// tb/tb_axis_video_frame_checker.sv - directed and randomized bench for axis_video_frame_checker
module tb_axis_video_frame_checker;

  localparam int W = 10;
  localparam int H = 10;

  logic        sys_clk;
  logic        sys_aresetn;
  logic        hold;
  logic        clr_errors;
  logic [10:0] pixel_x;
  logic [10:0] line_y;
  logic        in_frame;
  logic        frame_done;
  logic [15:0] frame_count;
  logic [31:0] frame_sum;
  logic        err_early_tlast;
  logic        err_late_tlast;
  logic        err_missing_tuser;
  logic        err_unexpected_tuser;
  logic [15:0] drop_count;

  axis_video_frame_checker_if #(.N(8)) s_axis ();

  axis_video_frame_checker #(.N(8), .width(W), .height(H)) dut (
    .sys_clk              (sys_clk),
    .sys_aresetn          (sys_aresetn),
    .s_axis               (s_axis),
    .hold                 (hold),
    .clr_errors           (clr_errors),
    .pixel_x              (pixel_x),
    .line_y               (line_y),
    .in_frame             (in_frame),
    .frame_done           (frame_done),
    .frame_count          (frame_count),
    .frame_sum            (frame_sum),
    .err_early_tlast      (err_early_tlast),
    .err_late_tlast       (err_late_tlast),
    .err_missing_tuser    (err_missing_tuser),
    .err_unexpected_tuser (err_unexpected_tuser),
    .drop_count           (drop_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;

  // Reference model: position as plain integers, sums with 32-bit wrap.
  bit          m_ready, m_in, m_done;
  int          mx, my;
  logic [31:0] m_acc, m_sum;
  logic [15:0] m_count, m_drop;
  bit          m_early, m_late, m_miss, m_unexp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ready = 0; m_in = 0; m_done = 0; mx = 0; my = 0;
    m_acc = 0; m_sum = 0; m_count = 0; m_drop = 0;
    m_early = 0; m_late = 0; m_miss = 0; m_unexp = 0;
  endtask

  task automatic model_beat(input logic [7:0] d, input logic l, input logic u);
    if (!m_in) begin
      if (!u) begin
        if (m_drop != 16'hFFFF) m_drop = m_drop + 1;
        m_miss = 1;
      end else begin
        m_in = 1; m_acc = 32'(d); mx = 1; my = 0;
      end
    end else if (u) begin
      m_unexp = 1; m_acc = 32'(d); mx = 1; my = 0;
    end else begin
      m_acc = m_acc + 32'(d);
      if (l && mx < W - 1) m_early = 1;
      if (!l && mx == W - 1) m_late = 1;
      if (l || mx == W - 1) begin
        mx = 0;
        if (my == H - 1) begin
          m_done = 1; m_count = m_count + 1; m_sum = m_acc; my = 0; m_in = 0;
        end else begin
          my = my + 1;
        end
      end else begin
        mx = mx + 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("tready", 32'(s_axis.tready), 32'(m_ready));
    chk("pixel_x", 32'(pixel_x), 32'(mx));
    chk("line_y", 32'(line_y), 32'(my));
    chk("in_frame", 32'(in_frame), 32'(m_in));
    chk("frame_done", 32'(frame_done), 32'(m_done));
    chk("frame_count", 32'(frame_count), 32'(m_count));
    chk("frame_sum", frame_sum, m_sum);
    chk("err_early", 32'(err_early_tlast), 32'(m_early));
    chk("err_late", 32'(err_late_tlast), 32'(m_late));
    chk("err_missing", 32'(err_missing_tuser), 32'(m_miss));
    chk("err_unexp", 32'(err_unexpected_tuser), 32'(m_unexp));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic l, input logic u,
                      input logic h, input logic c, output logic accepted);
    s_axis.tvalid = v; s_axis.tdata = d; s_axis.tlast = l; s_axis.tuser = u;
    hold = h; clr_errors = c;
    @(posedge sys_clk);
    accepted = v && m_ready;
    m_ready = !h;
    m_done = 0;
    if (c) begin
      m_early = 0; m_late = 0; m_miss = 0; m_unexp = 0; m_drop = 0;
    end
    if (accepted) model_beat(d, l, u);
    #1;
    compare_all();
    if (frame_done) done_seen++;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, a);
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l, input logic u);
    logic a;
    int tries;
    a = 1'b0;
    tries = 0;
    while (!a && tries < 50) begin
      step(1'b1, d, l, u, 1'b0, 1'b0, a);
      tries++;
    end
    if (!a) chk("beat_timeout", 32'(a), 32'd1);
  endtask

  task automatic apply_reset();
    sys_aresetn = 1'b0;
    s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tlast = 1'b0; s_axis.tuser = 1'b0;
    hold = 1'b0; clr_errors = 1'b0;
    #2;
    chk("rst_tready", 32'(s_axis.tready), 32'd0);
    chk("rst_pixel_x", 32'(pixel_x), 32'd0);
    chk("rst_line_y", 32'(line_y), 32'd0);
    chk("rst_in_frame", 32'(in_frame), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    chk("rst_sum", frame_sum, 32'd0);
    chk("rst_flags", 32'({err_early_tlast, err_late_tlast, err_missing_tuser, err_unexpected_tuser, frame_done}), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    sys_aresetn = 1'b1;
    model_reset();
    done_seen = 0;
  endtask

  initial begin
    logic a;
    int k;
    int len;
    model_reset();
    sys_aresetn = 1'b0;
    #1;
    apply_reset();
    idle(1);
    chk("tready_after_reset", 32'(s_axis.tready), 32'd1);

    // Clean frame
    for (int i = 0; i < 100; i++) send_beat(8'(i), (i % 10) == 9, i == 0);
    chk("clean_done_pulse", 32'(frame_done), 32'd1);
    chk("clean_done_count", 32'(done_seen), 32'd1);
    chk("clean_frame_count", 32'(frame_count), 32'd1);
    chk("clean_sum", frame_sum, 32'd4950);
    chk("clean_flags", 32'({err_early_tlast, err_late_tlast, err_missing_tuser, err_unexpected_tuser}), 32'd0);
    idle(2);
    chk("clean_single_pulse", 32'(done_seen), 32'd1);

    // Missing tlast on line 0
    apply_reset();
    idle(1);
    for (int i = 0; i < 100; i++) begin
      send_beat(8'(i), (i % 10) == 9 && i != 9, i == 0);
      if (i == 9) begin
        chk("late_line_y", 32'(line_y), 32'd1);
        chk("late_pixel_x", 32'(pixel_x), 32'd0);
      end
    end
    chk("late_done", 32'(frame_done), 32'd1);
    chk("late_count", 32'(frame_count), 32'd1);
    chk("late_flags", 32'({err_early_tlast, err_late_tlast, err_missing_tuser, err_unexpected_tuser}), 32'b0100);

    // Short first line
    apply_reset();
    idle(1);
    k = 0;
    for (int y = 0; y < H; y++) begin
      len = (y == 0) ? 8 : 10;
      for (int x = 0; x < len; x++) begin
        send_beat(8'(k), x == len - 1, k == 0);
        k++;
      end
    end
    chk("early_done", 32'(frame_done), 32'd1);
    chk("early_done_count", 32'(done_seen), 32'd1);
    chk("early_sum", frame_sum, 32'd4753);
    chk("early_flags", 32'({err_early_tlast, err_late_tlast, err_missing_tuser, err_unexpected_tuser}), 32'b1000);

    // 100 beats with no SOF, then a clean frame
    apply_reset();
    idle(1);
    for (int i = 0; i < 100; i++) send_beat(8'($urandom), 1'b0, 1'b0);
    chk("nosof_drop", 32'(drop_count), 32'd100);
    chk("nosof_missing", 32'(err_missing_tuser), 32'd1);
    chk("nosof_no_done", 32'(done_seen), 32'd0);
    for (int i = 0; i < 100; i++) send_beat(8'(i), (i % 10) == 9, i == 0);
    chk("nosof_count", 32'(frame_count), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, a);
    chk("clr_missing", 32'(err_missing_tuser), 32'd0);
    chk("clr_drop", 32'(drop_count), 32'd0);

    // Re-SOF at beat 50
    apply_reset();
    idle(1);
    for (int i = 0; i < 50; i++) send_beat(8'(i), (i % 10) == 9, i == 0);
    for (int i = 0; i < 100; i++) begin
      send_beat(8'(i), (i % 10) == 9, i == 0);
      if (i == 98) chk("resof_no_early_done", 32'(done_seen), 32'd0);
    end
    chk("resof_done", 32'(frame_done), 32'd1);
    chk("resof_count", 32'(frame_count), 32'd1);
    chk("resof_sum", frame_sum, 32'd4950);
    chk("resof_unexp", 32'(err_unexpected_tuser), 32'd1);

    // Backpressure, then asynchronous reset mid-frame
    apply_reset();
    idle(1);
    for (int i = 0; i < 4; i++) send_beat(8'(i), 1'b0, i == 0);
    step(1'b1, 8'd4, 1'b0, 1'b0, 1'b1, 1'b0, a);
    chk("hold_first_accept", 32'(a), 32'd1);
    chk("hold_tready_0", 32'(s_axis.tready), 32'd0);
    for (int i = 1; i < 5; i++) begin
      step(1'b1, 8'd5, 1'b0, 1'b0, 1'b1, 1'b0, a);
      chk("hold_tready", 32'(s_axis.tready), 32'd0);
      chk("hold_pixel_x", 32'(pixel_x), 32'd5);
    end
    step(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, a);
    chk("hold_last_frozen", 32'(pixel_x), 32'd5);
    chk("hold_release", 32'(s_axis.tready), 32'd1);
    send_beat(8'd5, 1'b0, 1'b0);
    apply_reset();
    idle(1);
    for (int i = 0; i < 100; i++) send_beat(8'(i), (i % 10) == 9, i == 0);
    chk("post_reset_count", 32'(frame_count), 32'd1);
    chk("post_reset_sum", frame_sum, 32'd4950);

    // Randomized traffic against the model
    apply_reset();
    for (int c = 0; c < 4000; c++) begin
      logic v, l, u, h, cl;
      v  = ($urandom_range(0, 9) < 8);
      h  = ($urandom_range(0, 9) == 0);
      cl = ($urandom_range(0, 199) == 0);
      u  = m_in ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 3) != 0);
      l  = (m_in && mx == W - 1) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 49) == 0);
      step(v, 8'($urandom), l, u, h, cl, a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
